multi_ch_sampler: RTL and testbench
===================================

# multi_ch_sampler

Parametrised, single-clock successor to the per-channel sampling register: captures NUM_CH pairs of asynchronous comparator outputs (high/low threshold), synchronises them, decimates by a programmable power of two, and packs SMPLS samples per channel into one output word. The block sits between the AFE comparator outputs and the capture RAM write path. It provides a valid/ready handshake with sticky overflow detection. It also exports synchronised per-channel levels to the trigger logic.

## Interface
- NUM_CH, 5: number of channels.
- SMPLS, 4: samples packed per channel per output word (≥1).
- SYNC_STAGES, 3: synchroniser depth (≥2).
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable.
- decimator  in  4  sample tick every 2^decimator enabled cycles.
- ch_h  in  NUM_CH  asynchronous high-threshold comparator outputs.
- ch_l  in  NUM_CH  asynchronous low-threshold comparator outputs.
- chh_sync  out  NUM_CH  synchronised ch_h (last sync stage), for trigger logic.
- chl_sync  out  NUM_CH  synchronised ch_l.
- smpl_data  out  NUM_CH*2*SMPLS  packed sample word.
- smpl_vld  out  1  smpl_data holds an unconsumed word.
- smpl_rdy  in  1  consumer accepts word when smpl_vld & smpl_rdy.
- ovfl  out  1  sticky: a completed word was dropped.
- clr_ovfl  in  1  clears ovfl.

## Operation
- Sync: each ch_h/ch_l bit passes through SYNC_STAGES flops; the last stage drives chh_sync/chl_sync.
- Decimation: 15-bit dec_cnt increments every cycle while en = 1, wraps naturally, and is forced to 0 while en = 0.
- tick = en & ((dec_cnt & mask) == mask), where mask = 2^decimator − 1. decimator = 0 gives a tick every enabled cycle.
- A decimator change takes effect on the next cycle with no counter reset.
- Packing: on each tick, every channel shifts {chh_sync, chl_sync} into its 2*SMPLS shift register, newest sample entering at the LSBs.
- A pack counter (0..SMPLS−1) increments on each tick.
- On the tick that completes sample SMPLS, the full word (including that sample) is offered to the output register and the pack counter returns to 0.
- Format: channel c occupies smpl_data[c*2*SMPLS +: 2*SMPLS]. Oldest sample is at the MSBs. Within each sample, H is the odd bit and L is the even bit.
- Output register behaviour when a word completes:
  - smpl_vld = 0: load the word; smpl_vld → 1.
  - smpl_vld = 1 and smpl_rdy = 1: load the word; smpl_vld stays 1.
  - smpl_vld = 1 and smpl_rdy = 0: drop the word; smpl_data is unchanged; ovfl → 1.
- With no word completing, smpl_vld & smpl_rdy clears smpl_vld.
- ovfl: set wins over a simultaneous clr_ovfl. clr_ovfl alone clears it next cycle.
- en = 0: dec_cnt and pack counter go to 0 and any partial word is discarded. The output register and handshake keep working, so a pending word can still drain.
- Reset (including mid-word or mid-handshake): all sync flops, dec_cnt, pack counter, shift registers, smpl_data, smpl_vld and ovfl go to 0. chh_sync/chl_sync read 0 until SYNC_STAGES cycles after reset release.

## Timing
- Pin-to-sync latency is SYNC_STAGES cycles: an input change at edge k is visible on chh_sync after edge k+SYNC_STAGES.
- The first tick after en rises occurs on enabled cycle 2^decimator − 1, counting from 0.
- smpl_vld asserts on the edge following the completing tick. smpl_data is valid in the same cycle.
- Word period is SMPLS * 2^decimator cycles. Overflow is impossible if smpl_rdy is high at least once per word period.

## Structure
- Package multi_ch_sampler_pkg holds:
  - smpl_t, a packed struct {h, l};
  - DEC_W = 4 and DEC_CNT_W = 15;
  - the default NUM_CH, SMPLS and SYNC_STAGES.
- Sub-module bit_sync: a parametrised SYNC_STAGES-deep synchroniser with synchronous reset. It is instantiated per bit via generate.

## Test plan
- Reset, then hold all inputs low for 10 cycles: all outputs are 0, and smpl_vld stays 0 with en = 0.
- NUM_CH = 5, SMPLS = 4, decimator = 0, en = 1, smpl_rdy = 1. Drive ch_h[1] pattern 1,0,1,1 on successive sync'd ticks with ch_l = 0 → channel 1 field = 8'h8A and all other fields 0. smpl_vld pulses for one cycle every 4 cycles.
- decimator = 2, constant ch_h = 5'h1F, ch_l = 0, smpl_rdy = 1 → one smpl_vld every 16 cycles, with every channel field = 8'hAA.
- smpl_rdy = 0, decimator = 0 → first word latched and smpl_vld = 1. The second completion 4 cycles later sets ovfl while smpl_data is unchanged. clr_ovfl and the set coinciding leaves ovfl = 1.
- Deassert en after 2 of 4 samples, then reassert → the next word contains only post-reassert samples. The first tick is on the first enabled cycle.
- Assert rst for 1 cycle mid-word with smpl_vld = 1 → all outputs 0 on the next cycle. The first new word arrives SMPLS * 2^decimator enabled cycles after reset release.

Source files
------------

// File: rtl/multi_ch_sampler_pkg.sv
// multi_ch_sampler_pkg: shared types and default sizes for the multi-channel sampler
package multi_ch_sampler_pkg;
  localparam int DEC_W = 4;
  localparam int DEC_CNT_W = 15;
  localparam int DEF_NUM_CH = 5;
  localparam int DEF_SMPLS = 4;
  localparam int DEF_SYNC_STAGES = 3;
  typedef struct packed {
    logic h;
    logic l;
  } smpl_t;
endpackage

// File: rtl/multi_ch_sampler_bit_sync.sv
// bit_sync: STAGES-deep single-bit synchroniser with synchronous reset
module bit_sync
  import multi_ch_sampler_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk) s <= rst ? '0 : {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/multi_ch_sampler.sv
// multi_ch_sampler: synchronises comparator pairs, decimates, packs SMPLS samples per channel
module multi_ch_sampler
  import multi_ch_sampler_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SMPLS = DEF_SMPLS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DEC_W-1:0]          decimator,
  input  logic [NUM_CH-1:0]         ch_h,
  input  logic [NUM_CH-1:0]         ch_l,
  output logic [NUM_CH-1:0]         chh_sync,
  output logic [NUM_CH-1:0]         chl_sync,
  output logic [NUM_CH*2*SMPLS-1:0] smpl_data,
  output logic                      smpl_vld,
  input  logic                      smpl_rdy,
  output logic                      ovfl,
  input  logic                      clr_ovfl
);
  localparam int SW = 2 * SMPLS;
  localparam int PW = SMPLS > 1 ? $clog2(SMPLS) : 1;
  smpl_t smpl [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bit_sync #(.STAGES(SYNC_STAGES)) u_h (.clk(clk), .rst(rst), .d(ch_h[g]), .q(chh_sync[g]));
    bit_sync #(.STAGES(SYNC_STAGES)) u_l (.clk(clk), .rst(rst), .d(ch_l[g]), .q(chl_sync[g]));
    assign smpl[g] = '{h: chh_sync[g], l: chl_sync[g]};
  end
  logic [DEC_CNT_W-1:0] dec_cnt, mask;
  logic [PW-1:0] pack_cnt;
  logic [NUM_CH*SW-1:0] sr, sr_nxt;
  logic tick, done;
  assign mask = DEC_CNT_W'((32'd1 << decimator) - 32'd1);
  assign tick = en && ((dec_cnt & mask) == mask);
  assign done = tick && (pack_cnt == PW'(SMPLS - 1));
  always_comb begin
    sr_nxt = sr;
    for (int c = 0; c < NUM_CH; c++)
      sr_nxt[c*SW +: SW] = (sr[c*SW +: SW] << 2) | SW'(smpl[c]);
  end
  // a dropped word leaves smpl_data intact; only ovfl records the loss
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt   <= '0;
      pack_cnt  <= '0;
      sr        <= '0;
      smpl_data <= '0;
      smpl_vld  <= 1'b0;
      ovfl      <= 1'b0;
    end else begin
      dec_cnt  <= en ? dec_cnt + 1'b1 : '0;
      pack_cnt <= (!en || done) ? '0 : tick ? pack_cnt + 1'b1 : pack_cnt;
      sr       <= !en ? '0 : tick ? sr_nxt : sr;
      if (done && (!smpl_vld || smpl_rdy)) begin
        smpl_data <= sr_nxt;
        smpl_vld  <= 1'b1;
      end else if (!done && smpl_vld && smpl_rdy) begin
        smpl_vld <= 1'b0;
      end
      ovfl <= (done && smpl_vld && !smpl_rdy) || (ovfl && !clr_ovfl);
    end
  end
endmodule

// File: tb/tb_multi_ch_sampler.sv
// tb_multi_ch_sampler: directed and random stimulus checked against a sample-list reference model
module tb_multi_ch_sampler;
  import multi_ch_sampler_pkg::*;
  localparam int NC = DEF_NUM_CH;
  localparam int SM = DEF_SMPLS;
  localparam int SS = DEF_SYNC_STAGES;
  localparam int W = NC * 2 * SM;
  logic clk = 0;
  logic rst = 1, en = 0, smpl_rdy = 0, clr_ovfl = 0;
  logic [DEC_W-1:0] decimator = '0;
  logic [NC-1:0] ch_h = '0, ch_l = '0, chh_sync, chl_sync;
  logic [W-1:0] smpl_data;
  logic smpl_vld, ovfl;
  int total = 0, bad = 0;
  bit chk_on = 0;
  multi_ch_sampler dut (
    .clk(clk), .rst(rst), .en(en), .decimator(decimator), .ch_h(ch_h), .ch_l(ch_l),
    .chh_sync(chh_sync), .chl_sync(chl_sync), .smpl_data(smpl_data), .smpl_vld(smpl_vld),
    .smpl_rdy(smpl_rdy), .ovfl(ovfl), .clr_ovfl(clr_ovfl)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference model: inputs logged per edge, samples collected into a list per word
  int n_edge = 0, last_rst = 0, run = 0;
  logic [NC-1:0] log_h [64], log_l [64];
  logic [2*NC-1:0] q [$];
  logic [W-1:0] m_data = '0;
  logic m_vld = 0, m_ovfl = 0;
  function automatic logic [NC-1:0] sync_of(input int n, input bit hi);
    if (n - SS + 1 <= last_rst) return '0;
    return hi ? log_h[(n - SS + 1) % 64] : log_l[(n - SS + 1) % 64];
  endfunction
  always @(posedge clk) begin
    int p;
    bit tick, set;
    logic [W-1:0] word;
    n_edge++;
    log_h[n_edge % 64] = ch_h;
    log_l[n_edge % 64] = ch_l;
    if (rst) begin
      last_rst = n_edge;
      run = 0;
      q.delete();
      m_data = '0;
      m_vld = 0;
      m_ovfl = 0;
    end else begin
      p = 1 << decimator;
      tick = en && (run % p == p - 1);
      set = 0;
      if (tick) q.push_back({sync_of(n_edge - 1, 1), sync_of(n_edge - 1, 0)});
      if (tick && q.size() == SM) begin
        word = '0;
        for (int s = 0; s < SM; s++)
          for (int c = 0; c < NC; c++) begin
            word[c*2*SM + 2*(SM-1-s) + 1] = q[s][NC + c];
            word[c*2*SM + 2*(SM-1-s)]     = q[s][c];
          end
        q.delete();
        if (!m_vld || smpl_rdy) begin
          m_data = word;
          m_vld = 1;
        end else set = 1;
      end else if (m_vld && smpl_rdy) m_vld = 0;
      m_ovfl = set ? 1'b1 : clr_ovfl ? 1'b0 : m_ovfl;
      if (en) run++;
      else begin
        run = 0;
        q.delete();
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    check("chh", 64'(chh_sync), 64'(sync_of(n_edge, 1)));
    check("chl", 64'(chl_sync), 64'(sync_of(n_edge, 0)));
    check("vld", 64'(smpl_vld), 64'(m_vld));
    check("data", 64'(smpl_data), 64'(m_data));
    check("ovfl", 64'(ovfl), 64'(m_ovfl));
  end
  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] saved;
    int cnt;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_on = 1;
    repeat (10) begin
      @(negedge clk);
      check("idle_vld", 64'(smpl_vld), 64'd0);
    end
    check("idle_data", 64'(smpl_data), 64'd0);
    check("idle_ovfl", 64'(ovfl), 64'd0);
    smpl_rdy = 1;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      ch_h = pat[i % 4] ? NC'(2) : '0;
      en = (i >= SS);
      @(negedge clk);
      if (smpl_vld) begin
        cnt++;
        check("c1_8a", 64'(smpl_data), 64'h8A00);
      end
    end
    check("pulses_d0", 64'(cnt), 64'd5);
    en = 0;
    ch_h = '1;
    ch_l = '0;
    decimator = 2;
    repeat (SS + 1) @(negedge clk);
    en = 1;
    cnt = 0;
    repeat (64) begin
      @(negedge clk);
      if (smpl_vld) begin
        cnt++;
        check("all_aa", 64'(smpl_data), 64'hAA_AAAA_AAAA);
      end
    end
    check("pulses_d2", 64'(cnt), 64'd4);
    en = 0;
    decimator = 0;
    @(negedge clk);
    smpl_rdy = 0;
    en = 1;
    repeat (4) begin
      ch_h = NC'($urandom);
      ch_l = NC'($urandom);
      @(negedge clk);
    end
    check("first_vld", 64'(smpl_vld), 64'd1);
    saved = smpl_data;
    repeat (4) begin
      ch_h = NC'($urandom);
      ch_l = NC'($urandom);
      @(negedge clk);
    end
    check("ovfl_set", 64'(ovfl), 64'd1);
    check("data_held", 64'(smpl_data), 64'(saved));
    repeat (3) @(negedge clk);
    clr_ovfl = 1;
    @(negedge clk);
    check("set_wins", 64'(ovfl), 64'd1);
    en = 0;
    @(negedge clk);
    check("ovfl_clr", 64'(ovfl), 64'd0);
    clr_ovfl = 0;
    smpl_rdy = 1;
    @(negedge clk);
    ch_h = '1;
    ch_l = '0;
    en = 1;
    repeat (2) @(negedge clk);
    en = 0;
    ch_h = '0;
    ch_l = '1;
    repeat (SS + 2) @(negedge clk);
    en = 1;
    repeat (3) @(negedge clk);
    check("reen_vld0", 64'(smpl_vld), 64'd0);
    @(negedge clk);
    check("reen_vld1", 64'(smpl_vld), 64'd1);
    check("reen_55", 64'(smpl_data), 64'h55_5555_5555);
    smpl_rdy = 0;
    repeat (2) @(negedge clk);
    check("pre_rst_vld", 64'(smpl_vld), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_vld", 64'(smpl_vld), 64'd0);
    check("rst_data", 64'(smpl_data), 64'd0);
    check("rst_chl", 64'(chl_sync), 64'd0);
    check("rst_ovfl", 64'(ovfl), 64'd0);
    repeat (3) @(negedge clk);
    check("post_rst_vld0", 64'(smpl_vld), 64'd0);
    @(negedge clk);
    check("post_rst_vld1", 64'(smpl_vld), 64'd1);
    repeat (3000) begin
      rst = ($urandom % 200) == 0;
      en = ($urandom % 8) != 0;
      if ($urandom % 50 == 0) decimator = DEC_W'($urandom_range(0, 3));
      ch_h = NC'($urandom);
      ch_l = NC'($urandom);
      smpl_rdy = ($urandom % 3) != 0;
      clr_ovfl = ($urandom % 20) == 0;
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
